// File: rtl/p_accum_bank_pkg.sv
// Shared defaults and state encoding for the p_accum_bank accumulator bank.
package p_accum_bank_pkg;

  localparam int unsigned DefChannels = 8;
  localparam int unsigned DefInW      = 8;
  localparam int unsigned DefAccW     = 16;
  localparam int unsigned DefDepth    = 16;

  typedef enum logic {
    StAccum = 1'b0,
    StHold  = 1'b1
  } state_e;

endpackage

// File: rtl/p_accum_lane.sv
// One accumulator lane: sign-extending adder, overflow detect, wrap or clamp (PACC_SATURATE_EN).
module p_accum_lane #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned ACC_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             clear,
  input  logic [IN_W-1:0]  X,
  output logic [ACC_W-1:0] S,
  output logic             ovf
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] x_ext;
  logic [ACC_W-1:0] sum;
  logic             ovf_now;

  assign x_ext = ACC_W'($signed(X));
  assign sum   = acc_q + x_ext;
  // Same-sign operands producing a result of the other sign.
  assign ovf_now = (acc_q[ACC_W-1] == x_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (clear) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (en) begin
      acc_d = sum;
      if (ovf_now) begin
        ovf_d = 1'b1;
`ifdef PACC_SATURATE_EN
        acc_d = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign S   = acc_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/p_accum_bank.sv
// Multi-lane accumulator bank: collects DEPTH beats per frame, then holds sums until consumed.
// Lane overflow behaviour selected by PACC_SATURATE_EN (clamp) or its absence (wrap).
module p_accum_bank
  import p_accum_bank_pkg::*;
#(
  parameter int unsigned CHANNELS = DefChannels,
  parameter int unsigned IN_W     = DefInW,
  parameter int unsigned ACC_W    = DefAccW,
  parameter int unsigned DEPTH    = DefDepth
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CHANNELS*IN_W-1:0]    weights_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CHANNELS*ACC_W-1:0]   sum_out,
  output logic [CHANNELS-1:0]         ovf,
  output logic [$clog2(DEPTH+1)-1:0]  beat_cnt
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            accept;
  logic            consume;

  assign accept  = in_valid && (state_q == StAccum);
  assign consume = out_ready && (state_q == StHold);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StAccum: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(DEPTH - 1)) begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d = StAccum;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= StAccum;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == StAccum);
  assign out_valid = (state_q == StHold);
  assign beat_cnt  = cnt_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    p_accum_lane #(
      .IN_W  (IN_W),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk   (clk),
      .clr   (clr),
      .en    (accept),
      .clear (consume),
      .X     (weights_in[c*IN_W +: IN_W]),
      .S     (sum_out[c*ACC_W +: ACC_W]),
      .ovf   (ovf[c])
    );
  end

endmodule

// File: tb/tb_p_accum_bank.sv
// Bench for p_accum_bank: three instances (16-bit, 8-bit and DEPTH=1) against a frame-level model.
module tb_p_accum_bank;

  logic        clk;
  logic        clr;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] weights;
  logic        c_valid;
  logic        c_ready;

  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid, c_in_ready, c_out_valid;
  logic [63:0] a_sum, c_sum;
  logic [31:0] b_sum;
  logic [3:0]  a_ovf, b_ovf, c_ovf;
  logic [2:0]  a_cnt, b_cnt;
  logic [0:0]  c_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Model: plain integer sums per lane, frame status as flag + count.
  int m16[4], m8[4], mc[4];
  bit o16[4], o8[4], oc[4];
  int m_cnt, mc_cnt;
  bit m_hold, mc_hold;

  p_accum_bank #(.CHANNELS(4), .IN_W(8), .ACC_W(16), .DEPTH(4)) dut_a (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(a_in_ready), .weights_in(weights),
    .out_valid(a_out_valid), .out_ready(out_ready), .sum_out(a_sum), .ovf(a_ovf),
    .beat_cnt(a_cnt)
  );

  p_accum_bank #(.CHANNELS(4), .IN_W(8), .ACC_W(8), .DEPTH(4)) dut_b (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(b_in_ready), .weights_in(weights),
    .out_valid(b_out_valid), .out_ready(out_ready), .sum_out(b_sum), .ovf(b_ovf),
    .beat_cnt(b_cnt)
  );

  p_accum_bank #(.CHANNELS(4), .IN_W(8), .ACC_W(16), .DEPTH(1)) dut_c (
    .clk(clk), .clr(clr), .in_valid(c_valid), .in_ready(c_in_ready), .weights_in(weights),
    .out_valid(c_out_valid), .out_ready(c_ready), .sum_out(c_sum), .ovf(c_ovf),
    .beat_cnt(c_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void step(input int acc, input int x, input int w,
                               output int nacc, output bit ov);
    int hi = (1 << (w - 1)) - 1;
    int lo = -(1 << (w - 1));
    int t  = acc + x;
    ov = (t > hi) || (t < lo);
`ifdef PACC_SATURATE_EN
    nacc = (t > hi) ? hi : (t < lo) ? lo : t;
`else
    nacc = (t > hi) ? t - (1 << w) : (t < lo) ? t + (1 << w) : t;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_in_ready", 32'(a_in_ready), 32'(!m_hold));
    chk("a_out_valid", 32'(a_out_valid), 32'(m_hold));
    chk("a_beat_cnt", 32'(a_cnt), 32'(m_cnt));
    chk("b_out_valid", 32'(b_out_valid), 32'(m_hold));
    chk("b_beat_cnt", 32'(b_cnt), 32'(m_cnt));
    chk("c_in_ready", 32'(c_in_ready), 32'(!mc_hold));
    chk("c_out_valid", 32'(c_out_valid), 32'(mc_hold));
    chk("c_beat_cnt", 32'(c_cnt), 32'(mc_cnt));
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("a_sum%0d", c), 32'(a_sum[c*16 +: 16]), 32'(m16[c]) & 32'hFFFF);
      chk($sformatf("b_sum%0d", c), 32'(b_sum[c*8 +: 8]), 32'(m8[c]) & 32'hFF);
      chk($sformatf("c_sum%0d", c), 32'(c_sum[c*16 +: 16]), 32'(mc[c]) & 32'hFFFF);
      chk($sformatf("a_ovf%0d", c), 32'(a_ovf[c]), 32'(o16[c]));
      chk($sformatf("b_ovf%0d", c), 32'(b_ovf[c]), 32'(o8[c]));
      chk($sformatf("c_ovf%0d", c), 32'(c_ovf[c]), 32'(oc[c]));
    end
  endtask

  // One clock: update the model from the inputs seen at the edge, then compare #1 later.
  task automatic tick();
    bit acc_ab = in_valid && !m_hold;
    bit con_ab = out_ready && m_hold;
    bit acc_c  = c_valid && !mc_hold;
    bit con_c  = c_ready && mc_hold;
    int x;
    @(posedge clk);
    for (int c = 0; c < 4; c++) begin
      x = int'($signed(weights[c*8 +: 8]));
      if (clr || con_ab) begin
        m16[c] = 0; m8[c] = 0; o16[c] = 0; o8[c] = 0;
      end else if (acc_ab) begin
        bit ov;
        step(m16[c], x, 16, m16[c], ov); o16[c] |= ov;
        step(m8[c], x, 8, m8[c], ov);    o8[c]  |= ov;
      end
      if (clr || con_c) begin
        mc[c] = 0; oc[c] = 0;
      end else if (acc_c) begin
        bit ov;
        step(mc[c], x, 16, mc[c], ov); oc[c] |= ov;
      end
    end
    if (clr || con_ab) begin
      m_cnt = 0; m_hold = 0;
    end else if (acc_ab) begin
      m_cnt++;
      if (m_cnt == 4) m_hold = 1;
    end
    if (clr || con_c) begin
      mc_cnt = 0; mc_hold = 0;
    end else if (acc_c) begin
      mc_cnt = 1; mc_hold = 1;
    end
    #1;
    check_all();
  endtask

  task automatic consume_ab();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    bit pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    clr = 1'b1; in_valid = 1'b0; out_ready = 1'b0; weights = '0; c_valid = 1'b0; c_ready = 1'b0;
    m_cnt = 0; mc_cnt = 0; m_hold = 0; mc_hold = 0;
    for (int c = 0; c < 4; c++) begin
      m16[c] = 0; m8[c] = 0; mc[c] = 0; o16[c] = 0; o8[c] = 0; oc[c] = 0;
    end
    tick(); tick();
    clr = 1'b0;
    tick();

    // Four beats of {1,2,-3,127}
    in_valid = 1'b1;
    weights = {8'd127, 8'hFD, 8'd2, 8'd1};
    repeat (4) tick();
    in_valid = 1'b0;
    chk("t1_out_valid", 32'(a_out_valid), 32'd1);
    chk("t1_sum2", 32'(a_sum[32 +: 16]), 32'h0000FFF4);
    chk("t1_sum3", 32'(a_sum[48 +: 16]), 32'd508);

    // HOLD ignores inputs for 10 cycles, then one consume
    in_valid = 1'b1;
    repeat (10) begin
      weights = $urandom;
      tick();
    end
    chk("t2_beat_cnt", 32'(a_cnt), 32'd4);
    chk("t2_sum3", 32'(a_sum[48 +: 16]), 32'd508);
    consume_ab();
    in_valid = 1'b0;
    chk("t2_in_ready", 32'(a_in_ready), 32'd1);
    chk("t2_sum3_clr", 32'(a_sum[48 +: 16]), 32'd0);

    // Lane 0 fed 4x +100: overflows the 8-bit instance
    weights = 32'h0000_0064;
    in_valid = 1'b1;
    repeat (4) tick();
    in_valid = 1'b0;
`ifdef PACC_SATURATE_EN
    chk("t3_b_sum0", 32'(b_sum[7:0]), 32'h7F);
`else
    chk("t3_b_sum0", 32'(b_sum[7:0]), 32'h90);
`endif
    chk("t3_b_ovf0", 32'(b_ovf[0]), 32'd1);
    chk("t3_a_sum0", 32'(a_sum[15:0]), 32'd400);
    consume_ab();

    // Partial frame discarded by clr
    weights = {4{8'd5}};
    in_valid = 1'b1;
    tick(); tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t4_beat_cnt", 32'(a_cnt), 32'd0);
    chk("t4_sum0", 32'(a_sum[15:0]), 32'd0);
    repeat (4) tick();
    in_valid = 1'b0;
    chk("t4_sum0_full", 32'(a_sum[15:0]), 32'd20);
    consume_ab();

    // Gapped valid
    weights = {4{8'd3}};
    for (int i = 0; i < 7; i++) begin
      in_valid = pat[i];
      tick();
    end
    in_valid = 1'b0;
    chk("t5_out_valid", 32'(a_out_valid), 32'd1);
    chk("t5_sum1", 32'(a_sum[31:16]), 32'd12);
    consume_ab();

    // DEPTH=1 instance: -7 then +7, no carry-over
    weights = {4{8'hF9}};
    c_valid = 1'b1;
    tick();
    c_valid = 1'b0;
    chk("t6_out_valid", 32'(c_out_valid), 32'd1);
    chk("t6_sum0_neg", 32'(c_sum[15:0]), 32'h0000FFF9);
    c_ready = 1'b1;
    tick();
    c_ready = 1'b0;
    weights = {4{8'd7}};
    c_valid = 1'b1;
    tick();
    c_valid = 1'b0;
    chk("t6_sum0_pos", 32'(c_sum[15:0]), 32'd7);

    // Randomized traffic with occasional clr
    repeat (400) begin
      clr       = ($urandom_range(0, 39) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) == 0);
      c_valid   = $urandom_range(0, 1) == 1;
      c_ready   = $urandom_range(0, 1) == 1;
      weights   = $urandom;
      tick();
    end
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; c_valid = 1'b0; c_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
